controlador_cafe: RTL and testbench

Sequencing controller for the coffee machine. It accumulates inserted coins into a credit register and validates the one-hot coffee selection against the fixed price list. On acceptance it runs the preparation interval, then delivers the coffee-ready pulse together with the change. It sits between the coin acceptor / selection buttons and the brewing actuator, and is the stateful replacement for the purely combinational price check.

---
 rtl/cafe_pkg.sv | 37 +++
 rtl/temporizador_prep.sv | 26 ++
 rtl/controlador_cafe.sv | 147 ++++++++++++++
 tb/tb_controlador_cafe.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cafe_pkg.sv
// Shared types and constants for the coffee machine controller:
// FSM states, the fixed price list and the one-hot selection decoder.
package cafe_pkg;

    localparam int W_CREDITO = 4;

    typedef enum logic [2:0] {
        IDLE,
        COBRANDO,
        PREPARANDO,
        ENTREGA,
        DEVOLVER
    } estado_t;

    localparam logic [W_CREDITO-1:0] PRECIO [4] = '{4'd3, 4'd4, 4'd5, 4'd7};

    typedef struct packed {
        logic       valido;
        logic [1:0] indice;
    } seleccion_t;

    // Anything other than exactly one button pressed is not a selection
    function automatic seleccion_t decodificar_cafe(input logic [3:0] cafe);
        seleccion_t sel;
        sel.valido = 1'b1;
        sel.indice = 2'd0;
        case (cafe)
            4'b0001: sel.indice = 2'd0;
            4'b0010: sel.indice = 2'd1;
            4'b0100: sel.indice = 2'd2;
            4'b1000: sel.indice = 2'd3;
            default: sel.valido = 1'b0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/temporizador_prep.sv
// Loadable 8-bit down-counter that times the brewing interval.
// cero flags the enabled cycle in which the count steps down to zero.
module temporizador_prep (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       en,
    input  logic [7:0] valor,
    output logic       cero
);

    logic [7:0] cuenta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cuenta <= 8'd0;
        end else if (load) begin
            cuenta <= valor;
        end else if (en && (cuenta != 8'd0)) begin
            cuenta <= cuenta - 8'd1;
        end
    end

    assign cero = en && (cuenta == 8'd1);

endmodule

// File: rtl/controlador_cafe.sv
// Coffee machine sequencing controller: credit accumulation, selection, brewing and change.
// Define CANCELAR_PREP_EN to let cancelar abort an ongoing preparation with a full refund.
module controlador_cafe
    import cafe_pkg::*;
#(
    parameter int unsigned T_PREP = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 moneda_valida,
    input  logic [3:0]           moneda_valor,
    input  logic [3:0]           cafe,
    input  logic                 cancelar,
    output logic [W_CREDITO-1:0] credito,
    output logic [1:0]           tipoCafe,
    output logic                 preparando,
    output logic                 cafe_listo,
    output logic [W_CREDITO-1:0] vuelto,
    output logic                 vuelto_valido,
    output logic                 moneda_rechazada
);

    estado_t               estado, estado_sig;
    logic [W_CREDITO-1:0]  cambio, cambio_sig, credito_sig, vuelto_sig;
    logic [1:0]            tipo_sig;
    logic                  preparando_sig, listo_sig, vvalido_sig, rechazo_sig;
    logic                  carga, cuenta_en, cero, moneda;
    logic [W_CREDITO:0]    suma;
    seleccion_t            sel;

    temporizador_prep u_temporizador (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (carga),
        .en    (cuenta_en),
        .valor (8'(T_PREP)),
        .cero  (cero)
    );

    assign moneda = moneda_valida && (moneda_valor != 4'd0);
    assign suma   = {1'b0, credito} + {1'b0, moneda_valor};
    assign sel    = decodificar_cafe(cafe);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado           <= IDLE;
            credito          <= '0;
            cambio           <= '0;
            tipoCafe         <= 2'd0;
            preparando       <= 1'b0;
            cafe_listo       <= 1'b0;
            vuelto           <= '0;
            vuelto_valido    <= 1'b0;
            moneda_rechazada <= 1'b0;
        end else begin
            estado           <= estado_sig;
            credito          <= credito_sig;
            cambio           <= cambio_sig;
            tipoCafe         <= tipo_sig;
            preparando       <= preparando_sig;
            cafe_listo       <= listo_sig;
            vuelto           <= vuelto_sig;
            vuelto_valido    <= vvalido_sig;
            moneda_rechazada <= rechazo_sig;
        end
    end

    // Outputs are computed for the state being entered, so they appear registered with it
    always_comb begin
        estado_sig     = estado;
        credito_sig    = credito;
        cambio_sig     = cambio;
        tipo_sig       = tipoCafe;
        preparando_sig = 1'b0;
        listo_sig      = 1'b0;
        vuelto_sig     = '0;
        vvalido_sig    = 1'b0;
        rechazo_sig    = 1'b0;
        carga          = 1'b0;
        cuenta_en      = 1'b0;

        case (estado)
            IDLE: begin
                if (moneda) begin
                    credito_sig = moneda_valor;
                    estado_sig  = COBRANDO;
                end
            end

            COBRANDO: begin
                if (cancelar) begin
                    estado_sig  = DEVOLVER;
                    vvalido_sig = 1'b1;
                    vuelto_sig  = credito;
                    rechazo_sig = moneda;
                end else if (sel.valido && (credito >= PRECIO[sel.indice])) begin
                    estado_sig     = PREPARANDO;
                    tipo_sig       = sel.indice;
                    cambio_sig     = credito - PRECIO[sel.indice];
                    preparando_sig = 1'b1;
                    carga          = 1'b1;
                    rechazo_sig    = moneda;
                end else if (moneda) begin
                    if (suma[W_CREDITO] == 1'b0) begin
                        credito_sig = suma[W_CREDITO-1:0];
                    end else begin
                        rechazo_sig = 1'b1;
                    end
                end
            end

            // Credit is kept intact while brewing so an abort can refund all of it
            PREPARANDO: begin
                rechazo_sig    = moneda;
                cuenta_en      = 1'b1;
                preparando_sig = 1'b1;
`ifdef CANCELAR_PREP_EN
                if (cancelar) begin
                    estado_sig     = DEVOLVER;
                    preparando_sig = 1'b0;
                    vvalido_sig    = 1'b1;
                    vuelto_sig     = credito;
                end else
`endif
                if (cero) begin
                    estado_sig     = ENTREGA;
                    preparando_sig = 1'b0;
                    listo_sig      = 1'b1;
                    vvalido_sig    = 1'b1;
                    vuelto_sig     = cambio;
                end
            end

            ENTREGA, DEVOLVER: begin
                rechazo_sig = moneda;
                credito_sig = '0;
                estado_sig  = IDLE;
            end

            default: begin
                estado_sig  = IDLE;
                credito_sig = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_controlador_cafe.sv
// Self-checking bench for controlador_cafe: directed test-plan scenarios with literal
// expectations, then randomized traffic, all compared every cycle against a behavioural model.
module tb_controlador_cafe;

    localparam int T_PREP = 8;
`ifdef CANCELAR_PREP_EN
    localparam bit CANCEL_EN = 1'b1;
`else
    localparam bit CANCEL_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       moneda_valida;
    logic [3:0] moneda_valor;
    logic [3:0] cafe;
    logic       cancelar;
    logic [3:0] credito;
    logic [1:0] tipoCafe;
    logic       preparando;
    logic       cafe_listo;
    logic [3:0] vuelto;
    logic       vuelto_valido;
    logic       moneda_rechazada;

    int vectors    = 0;
    int miscompares = 0;

    int precio [4] = '{3, 4, 5, 7};

    // Model: a session is described only by the amounts involved and the brew time left
    int m_credit, m_change, m_tipo, m_brew;
    bit m_after;
    int e_rech, e_listo, e_vv, e_vuelto;

    controlador_cafe #(.T_PREP(T_PREP)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .moneda_valida    (moneda_valida),
        .moneda_valor     (moneda_valor),
        .cafe             (cafe),
        .cancelar         (cancelar),
        .credito          (credito),
        .tipoCafe         (tipoCafe),
        .preparando       (preparando),
        .cafe_listo       (cafe_listo),
        .vuelto           (vuelto),
        .vuelto_valido    (vuelto_valido),
        .moneda_rechazada (moneda_rechazada)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    function automatic int oneHotIndex(input logic [3:0] c);
        if ($countones(c) != 1) return -1;
        for (int i = 0; i < 4; i++) begin
            if (c[i]) return i;
        end
        return -1;
    endfunction

    task automatic modelReset();
        m_credit = 0; m_change = 0; m_tipo = 0; m_brew = 0; m_after = 1'b0;
        e_rech = 0; e_listo = 0; e_vv = 0; e_vuelto = 0;
    endtask

    task automatic modelStep();
        bit coin;
        int idx;
        coin = moneda_valida && (moneda_valor != 4'd0);
        e_rech = 0; e_listo = 0; e_vv = 0; e_vuelto = 0;
        if (!rst_n) begin
            modelReset();
        end else if (m_after) begin
            m_after  = 1'b0;
            m_credit = 0;
            e_rech   = int'(coin);
        end else if (m_brew > 0) begin
            e_rech = int'(coin);
            if (CANCEL_EN && cancelar) begin
                m_brew = 0; e_vv = 1; e_vuelto = m_credit; m_after = 1'b1;
            end else begin
                m_brew--;
                if (m_brew == 0) begin
                    e_listo = 1; e_vv = 1; e_vuelto = m_change; m_after = 1'b1;
                end
            end
        end else if (m_credit == 0) begin
            if (coin) m_credit = int'(moneda_valor);
        end else begin
            idx = oneHotIndex(cafe);
            if (cancelar) begin
                e_vv = 1; e_vuelto = m_credit; m_after = 1'b1; e_rech = int'(coin);
            end else if (idx >= 0 && m_credit >= precio[idx]) begin
                m_tipo = idx; m_change = m_credit - precio[idx]; m_brew = T_PREP;
                e_rech = int'(coin);
            end else if (coin) begin
                if (m_credit + int'(moneda_valor) <= 15) m_credit += int'(moneda_valor);
                else e_rech = 1;
            end
        end
    endtask

    always @(negedge clk) begin
        checkOutput("credito",          int'(credito),          m_credit);
        checkOutput("tipoCafe",         int'(tipoCafe),         m_tipo);
        checkOutput("preparando",       int'(preparando),       int'(m_brew > 0));
        checkOutput("cafe_listo",       int'(cafe_listo),       e_listo);
        checkOutput("vuelto",           int'(vuelto),           e_vuelto);
        checkOutput("vuelto_valido",    int'(vuelto_valido),    e_vv);
        checkOutput("moneda_rechazada", int'(moneda_rechazada), e_rech);
    end

    task automatic applyStimulus(input logic mv, input logic [3:0] val,
                                 input logic [3:0] c, input logic cn);
        moneda_valida = mv; moneda_valor = val; cafe = c; cancelar = cn;
        @(posedge clk);
        modelStep();
        #1;
        moneda_valida = 1'b0; moneda_valor = 4'd0; cafe = 4'd0; cancelar = 1'b0;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0);
    endtask

    task automatic waitDelivery(output int prep_cycles);
        bit seen;
        prep_cycles = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (preparando) prep_cycles++;
            idle();
            if (cafe_listo) seen = 1'b1;
        end
        checkOutput("delivery_seen", int'(seen), 1);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_credito"},  int'(credito),  0);
        checkOutput({tag, "_tipo"},     int'(tipoCafe), 0);
        checkOutput({tag, "_prep"},     int'(preparando), 0);
        checkOutput({tag, "_listo"},    int'(cafe_listo), 0);
        checkOutput({tag, "_vuelto"},   int'(vuelto), 0);
        checkOutput({tag, "_vvalido"},  int'(vuelto_valido), 0);
        checkOutput({tag, "_rech"},     int'(moneda_rechazada), 0);
    endtask

    initial begin
        int pc;
        logic [3:0] c;
        moneda_valida = 1'b0; moneda_valor = 4'd0; cafe = 4'd0; cancelar = 1'b0;
        modelReset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        rst_n = 1'b1;

        // Coins 2+1, small coffee, zero change
        applyStimulus(1'b1, 4'd2, 4'd0, 1'b0);
        checkOutput("s1_credito2", int'(credito), 2);
        applyStimulus(1'b1, 4'd1, 4'd0, 1'b0);
        checkOutput("s1_credito3", int'(credito), 3);
        applyStimulus(1'b0, 4'd0, 4'b0001, 1'b0);
        checkOutput("s1_tipo", int'(tipoCafe), 0);
        waitDelivery(pc);
        checkOutput("s1_prep_cycles", pc, 8);
        checkOutput("s1_vvalido", int'(vuelto_valido), 1);
        checkOutput("s1_vuelto", int'(vuelto), 0);
        idle();
        checkOutput("s1_credito_clear", int'(credito), 0);

        // Coins 5+3, large coffee, change 1
        applyStimulus(1'b1, 4'd5, 4'd0, 1'b0);
        applyStimulus(1'b1, 4'd3, 4'd0, 1'b0);
        applyStimulus(1'b0, 4'd0, 4'b1000, 1'b0);
        checkOutput("s2_tipo", int'(tipoCafe), 3);
        waitDelivery(pc);
        checkOutput("s2_vuelto", int'(vuelto), 1);
        idle();

        // Insufficient credit, then cancel
        applyStimulus(1'b1, 4'd4, 4'd0, 1'b0);
        applyStimulus(1'b0, 4'd0, 4'b1000, 1'b0);
        checkOutput("s3_credito", int'(credito), 4);
        checkOutput("s3_prep", int'(preparando), 0);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b1);
        checkOutput("s3_vvalido", int'(vuelto_valido), 1);
        checkOutput("s3_vuelto", int'(vuelto), 4);
        idle();
        checkOutput("s3_credito_clear", int'(credito), 0);

        // Overflowing coin rejected
        applyStimulus(1'b1, 4'd12, 4'd0, 1'b0);
        applyStimulus(1'b1, 4'd5, 4'd0, 1'b0);
        checkOutput("s4_rech", int'(moneda_rechazada), 1);
        checkOutput("s4_credito", int'(credito), 12);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b1);
        idle();

        // Non-one-hot ignored, then cancel > cafe > coin
        applyStimulus(1'b1, 4'd9, 4'd0, 1'b0);
        applyStimulus(1'b0, 4'd0, 4'b0011, 1'b0);
        checkOutput("s5_ignored", int'(preparando), 0);
        checkOutput("s5_credito", int'(credito), 9);
        applyStimulus(1'b1, 4'd1, 4'b0100, 1'b1);
        checkOutput("s5_vvalido", int'(vuelto_valido), 1);
        checkOutput("s5_vuelto", int'(vuelto), 9);
        checkOutput("s5_rech", int'(moneda_rechazada), 1);
        checkOutput("s5_prep", int'(preparando), 0);
        idle();

        // Cancel during preparation
        applyStimulus(1'b1, 4'd7, 4'd0, 1'b0);
        applyStimulus(1'b0, 4'd0, 4'b0010, 1'b0);
        repeat (3) idle();
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b1);
`ifdef CANCELAR_PREP_EN
        checkOutput("s6_vvalido", int'(vuelto_valido), 1);
        checkOutput("s6_vuelto", int'(vuelto), 7);
        checkOutput("s6_listo", int'(cafe_listo), 0);
        checkOutput("s6_prep", int'(preparando), 0);
`else
        checkOutput("s6_prep_kept", int'(preparando), 1);
        waitDelivery(pc);
        checkOutput("s6_vuelto", int'(vuelto), 3);
`endif
        idle();

        // Reset mid-preparation
        applyStimulus(1'b1, 4'd7, 4'd0, 1'b0);
        applyStimulus(1'b0, 4'd0, 4'b0010, 1'b0);
        repeat (4) idle();
        rst_n = 1'b0;
        modelReset();
        #1;
        checkAllZero("s7_reset");
        idle();
        rst_n = 1'b1;
        applyStimulus(1'b1, 4'd3, 4'd0, 1'b0);
        checkOutput("s7_idle_coin", int'(credito), 3);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b1);
        idle();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 3))
                0: c = 4'b0001 << $urandom_range(0, 3);
                1: c = 4'($urandom_range(0, 15));
                default: c = 4'd0;
            endcase
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 1'b0;
                modelReset();
            end
            applyStimulus($urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)), c,
                          $urandom_range(0, 24) == 0);
            rst_n = 1'b1;
        end

        repeat (2) idle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
